// File: rtl/inst_queue.sv
// inst_queue: in-order instruction buffer between fetch and decode.
// Holds up to DEPTH {inst, pc, is_jump, is_branch} entries and predecodes
// j / beq at enqueue time so decode reads ready-made flags.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high on that side. in_ready depends only on the registered count, so
// a full queue refuses a word even when decode is consuming in the same
// cycle. out_valid and the head fields depend only on registered state.
// Upstream may drop in_valid without a transfer. While out_valid=1 and
// out_ready=0 the head fields do not change.
module inst_queue #(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_inst,
    input  logic [29:0]                in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_inst,
    output logic [29:0]                out_pc,
    output logic                       out_is_jump,
    output logic                       out_is_branch,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BEQ = 6'b000100;

    typedef struct packed {
        logic [31:0] inst;
        logic [29:0] pc;
        logic        is_jump;
        logic        is_branch;
    } entry_t;

    // Storage is deliberately left without reset; the count masks stale data.
    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];

    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] wr_ptr_d;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] rd_ptr_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    logic          enq;
    logic          deq;
    entry_t        in_entry;
    entry_t        head;

    // Predecode the incoming word into a storage entry.
    always_comb begin
        in_entry           = '0;
        in_entry.inst      = in_inst;
        in_entry.pc        = in_pc;
        in_entry.is_jump   = (in_inst[31:26] == OP_J);
        in_entry.is_branch = (in_inst[31:26] == OP_BEQ);
    end

    // Handshake qualifiers; flush suppresses the effect of both transfers.
    always_comb begin
        in_ready  = (count_q < CW'(DEPTH));
        out_valid = (count_q != '0);
        enq       = in_valid && in_ready && !flush;
        deq       = out_valid && out_ready && !flush;
    end

    // Next-state for pointers and occupancy; flush wins over everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({enq, deq})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Next-state for storage: only the slot at wr_ptr changes on enqueue.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (enq) begin
            mem_d[wr_ptr_q] = in_entry;
        end
    end

    // Control registers: cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage: plain registers with no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    // Head presentation: stored entry at rd_ptr, zeroed when empty.
    always_comb begin
        head = mem_q[rd_ptr_q];
        if (!out_valid) begin
            head = '0;
        end
        out_inst      = head.inst;
        out_pc        = head.pc;
        out_is_jump   = head.is_jump;
        out_is_branch = head.is_branch;
        count         = count_q;
    end

endmodule

// File: doc/inst_queue.md
# inst_queue

Instruction buffer between the instruction fetch unit and the decode stage. It accepts fetched instruction words with their word-aligned PC, stores up to DEPTH entries in order, and presents the oldest entry to decode under a valid/ready handshake. It predecodes `j` and `beq` at enqueue so decode can raise `jump` and `branch` without re-parsing. A flush discards all buffered entries when the fetch path redirects.

## Interface
- DEPTH, 2, number of entries; power of two, ≥ 2
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  fetch presents a word this cycle
- in_ready  output  1  queue can accept a word this cycle
- in_inst  input  32  fetched instruction
- in_pc  input  30  word address of in_inst, bits [31:2]
- out_valid  output  1  head entry is valid
- out_ready  input  1  decode consumes head this cycle
- out_inst  output  32  head instruction; 32'h0000_0000 (NOP) when empty
- out_pc  output  30  head word address; 0 when empty
- out_is_jump  output  1  head opcode == 6'b000010; 0 when empty
- out_is_branch  output  1  head opcode == 6'b000100; 0 when empty
- flush  input  1  synchronous discard of all entries
- count  output  clog2(DEPTH)+1  entries currently held

## Operation
- Storage: DEPTH entries of {inst[31:0], pc[31:2], is_jump, is_branch}. Write and read pointers are clog2(DEPTH) bits wide and wrap modulo DEPTH. Count is a separate register.
- Enqueue: occurs when in_valid && in_ready. Write the entry at wr_ptr, then wr_ptr+1. Predecode flags come from in_inst[31:26].
- Dequeue: occurs when out_valid && out_ready. Then rd_ptr+1.
- in_ready = (count < DEPTH). Full means in_ready=0 even if out_ready=1; there is no same-cycle pass-through.
- out_valid = (count != 0). Head outputs are a mux of the stored entry at rd_ptr, forced to 0 when empty.
- Count update:
  - enqueue only: +1
  - dequeue only: −1
  - both: unchanged
  - neither: unchanged
- Flush has priority over everything:
  - count, wr_ptr and rd_ptr go to 0.
  - A word presented with in_valid the same cycle is dropped.
  - A dequeue the same cycle is still treated as consumed by decode, but has no further effect.
  - in_ready is unaffected by flush; it reflects the pre-edge count.
- Storage contents are not cleared by reset or flush. Only the pointers and count are cleared. Outputs are masked by out_valid.
- Holding rule: while out_valid=1 and out_ready=0, the head outputs are stable.
- Upstream may drop in_valid without a handshake. The queue does not require it to hold.

## Timing
- Reset (rst_n=0, asynchronous): count=0 and pointers=0. Consequently out_valid=0, out_inst=0, out_pc=0, out_is_jump=0, out_is_branch=0, in_ready=1. These values hold for as long as rst_n is low.
- Reset deasserting mid-stream: all prior entries are lost. The first accepted word after release is the next head.
- Latency: a word enqueued at edge N is visible on the outputs right after edge N (one cycle, no bypass). With an empty queue and an in-flight write, out_valid stays 0 until that edge.
- Throughput: one word per cycle when out_ready is held high, for any DEPTH ≥ 2.
- Wrap-around: pointers roll from DEPTH−1 to 0 with no bubble.
- All outputs except in_ready/out_* masking are pure functions of registered state. Combinational paths from in_* or out_ready to any output are prohibited.

## Test plan
- Reset and idle: hold rst_n=0 for 3 cycles with in_valid=1 → count=0, out_valid=0, out_inst=0, in_ready=1. Release, enqueue 32'h2008_0005 at pc 30'h0000_0001 → next cycle out_valid=1, out_inst=32'h2008_0005, out_pc=1, out_is_jump=0.
- Fill and stall (DEPTH=2): enqueue A=32'h0800_0010 then B=32'h1000_FFFE with out_ready=0 → count=2, in_ready=0, head A with out_is_jump=1. A third word C is ignored. Raise out_ready for 2 cycles → A then B in order, with out_is_branch=1 on B, then count=0.
- Simultaneous enqueue/dequeue at count=1 for 8 cycles with incrementing pc → count stays 1, outputs appear in order, pointers wrap 4 times with no lost or duplicated pc.
- Flush: with count=2, assert flush together with in_valid=1 (word D) and out_ready=1 → next cycle count=0, out_valid=0, D absent. The next enqueued word becomes head.
- Async reset mid-operation: with count=2, pulse rst_n low between clock edges → outputs go to reset values immediately without waiting for an edge. After release, the queue behaves as empty.
- Random streaming: 1000 cycles of random in_valid, out_ready and flush against a scoreboard model → exact order and data match, and count never exceeds DEPTH.
